int_pow: RTL and testbench

Iterative integer power unit: computes `j = c ** g` using LSB-first square-and-multiply under a start/done handshake. It is the inverse companion of the integer-logarithm block. That block searches for the exponent of `c` that reaches a bound. This block takes a base and an exponent and regenerates the power, so software and test logic can round-trip values through both units. It sits beside the logarithm block on the same clock and shares its `c` / `start` / `enable` / `done` naming.

---
 rtl/int_pow.sv | 122 ++++++++++++
 tb/tb_int_pow.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/int_pow.sv
// Iterative integer power unit: j = c**g (mod 2^W) by LSB-first square-and-multiply.
// A start/done handshake is used, plus a sticky overflow flag for results that exceed W bits.
module int_pow #(
   parameter int W  = 16,
   parameter int EW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          enable,
   input  logic [W-1:0]  c,
   input  logic [EW-1:0] g,
   output logic [W-1:0]  j,
   output logic          done,
   output logic          ovf,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  base_q, base_d;
   logic [EW-1:0] e_q, e_d;
   logic [W-1:0]  acc_q, acc_d;
   logic          base_ovf_q, base_ovf_d;
   logic          acc_ovf_q, acc_ovf_d;
   logic [W-1:0]  j_q, j_d;
   logic          ovf_q, ovf_d;
   logic          done_q, done_d;
   logic [2*W-1:0] acc_prod, base_sq;

   function automatic logic [2*W-1:0] mul_full(input logic [W-1:0] a, input logic [W-1:0] b);
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
   endfunction

   function automatic logic hi_nz(input logic [2*W-1:0] p);
      return |p[2*W-1:W];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         e_q        <= '0;
         acc_q      <= W'(1);
         base_ovf_q <= 1'b0;
         acc_ovf_q  <= 1'b0;
         j_q        <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         e_q        <= e_d;
         acc_q      <= acc_d;
         base_ovf_q <= base_ovf_d;
         acc_ovf_q  <= acc_ovf_d;
         j_q        <= j_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      e_d        = e_q;
      acc_d      = acc_q;
      base_ovf_d = base_ovf_q;
      acc_ovf_d  = acc_ovf_q;
      j_d        = j_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      acc_prod   = mul_full(acc_q, base_q);
      base_sq    = mul_full(base_q, base_q);

      case (state_q)
         IDLE: begin
            if (start && enable) begin
               base_d     = c;
               e_d        = g;
               acc_d      = W'(1);
               base_ovf_d = 1'b0;
               acc_ovf_d  = 1'b0;
               state_d    = CALC;
            end
         end
         CALC: begin
            if (enable) begin
               if (e_q == '0) begin
                  j_d     = acc_q;
                  ovf_d   = acc_ovf_q;
                  done_d  = 1'b1;
                  state_d = FIN;
               end else begin
                  // base_ovf only reaches acc_ovf through a multiply, so the
                  // squaring after the top exponent bit can never leak into ovf.
                  if (e_q[0]) begin
                     acc_d     = acc_prod[W-1:0];
                     acc_ovf_d = acc_ovf_q | base_ovf_q | hi_nz(acc_prod);
                  end
                  base_d     = base_sq[W-1:0];
                  base_ovf_d = base_ovf_q | hi_nz(base_sq);
                  e_d        = e_q >> 1;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign j    = j_q;
   assign ovf  = ovf_q;
   assign done = done_q;
   assign busy = (state_q == CALC) || (state_q == FIN);

endmodule

// File: tb/tb_int_pow.sv
// Scoreboard bench for int_pow: expected results are queued at request time
// and matched against each done pulse, including the cycle it arrives in.
module tb_int_pow;
   localparam int W  = 16;
   localparam int EW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          enable = 1'b0;
   logic [W-1:0]  c = '0;
   logic [EW-1:0] g = '0;
   logic [W-1:0]  j;
   logic          done;
   logic          ovf;
   logic          busy;

   int_pow #(.W(W), .EW(EW)) dut (
      .clk(clk), .rst(rst), .start(start), .enable(enable),
      .c(c), .g(g), .j(j), .done(done), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint ej;
      longint eovf;
      int     ecyc;
      string  tag;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic done_prev = 1'b0;
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference: repeated multiplication with a sticky overflow flag.
   function automatic void model(input longint cc, input longint gg,
                                 output longint rj, output longint rovf);
      longint p;
      p = 1;
      rovf = 0;
      for (longint i = 0; i < gg; i++) begin
         p = p * cc;
         if (p > 65535) begin
            rovf = 1;
            p = p % 65536;
         end
      end
      rj = p;
   endfunction

   function automatic int blen(input longint v);
      int n;
      n = 0;
      while (v != 0) begin
         n++;
         v = v >> 1;
      end
      return n;
   endfunction

   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, "_j"}, longint'(j), mon_e.ej);
            chk({mon_e.tag, "_ovf"}, longint'(ovf), mon_e.eovf);
            chk({mon_e.tag, "_done_cycle"}, longint'(cyc), longint'(mon_e.ecyc));
            chk({mon_e.tag, "_busy_at_done"}, longint'(busy), 1);
         end
         chk("done_pulse", longint'(done_prev), 0);
      end
      done_prev = done;
   end

   task automatic req(input longint cc, input longint gg, input int stalls, input string tag);
      exp_t   e;
      longint rj;
      longint rovf;
      int     k;
      @(negedge clk);
      c = W'(cc);
      g = EW'(gg);
      start = 1'b1;
      enable = 1'b1;
      model(cc, gg, rj, rovf);
      e.ej = rj;
      e.eovf = rovf;
      e.ecyc = cyc + 1 + blen(gg) + 1 + stalls;
      e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      c = W'($urandom);
      g = EW'($urandom);
      if (stalls > 0) begin
         enable = 1'b0;
         repeat (stalls) @(negedge clk);
         enable = 1'b1;
      end
      k = 0;
      while (sb.size() != 0 && k < 300) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (sb.size() != 0) begin
         chk({tag, "_timeout"}, 0, 1);
         sb.delete();
      end else begin
         @(negedge clk);
         chk({tag, "_busy_fall"}, longint'(busy), 0);
         chk({tag, "_done_low"}, longint'(done), 0);
         chk({tag, "_j_hold"}, longint'(j), rj);
         chk({tag, "_ovf_hold"}, longint'(ovf), rovf);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_j", longint'(j), 0);
      chk("rst_ovf", longint'(ovf), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_busy", longint'(busy), 0);
      rst = 1'b0;

      // start without enable must not be accepted
      @(negedge clk);
      start = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_enable_busy", longint'(busy), 0);
      start = 1'b0;

      req(3, 4, 0, "p3_4");
      req(2, 15, 0, "p2_15");
      req(2, 16, 0, "p2_16");
      req(7, 0, 0, "p7_0");
      req(0, 0, 0, "p0_0");
      req(0, 9, 0, "p0_9");
      req(255, 2, 0, "p255_2");
      req(256, 2, 0, "p256_2");
      req(16, 3, 0, "p16_3");
      req(1, 65535, 0, "p1_max");
      req(1, 65535, 3, "p1_max_stall");
      req(3, 40, 2, "p3_40_stall");

      // reset in the middle of a calculation
      @(negedge clk);
      c = 3;
      g = 4;
      start = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_j", longint'(j), 0);
      chk("midrst_ovf", longint'(ovf), 0);
      chk("midrst_done", longint'(done), 0);
      chk("midrst_busy", longint'(busy), 0);
      repeat (8) @(negedge clk);
      chk("midrst_idle", longint'(busy), 0);
      req(5, 3, 0, "p5_3");

      for (int i = 0; i < 6; i++) begin
         req(longint'($urandom_range(0, 20)), longint'($urandom_range(0, 20)), 0, "rand");
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
      $fatal(1, "global timeout");
   end
endmodule
